// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: hands one shared K-bit datapath to N requesters
// with bounded tenure and a one-hot AND-OR output mux.
module rr_grant_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned K        = 8,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned IW       = 2,
  parameter int unsigned CW       = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*K-1:0] din,
  output logic [N-1:0]   grant,
  output logic [IW-1:0]  grant_idx,
  output logic           busy,
  output logic [K-1:0]   dout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] hold_q, hold_d;

  logic [IW-1:0] next_owner;
  logic [IW-1:0] arb_start;
  logic [IW-1:0] arb_idx;
  logic [N-1:0]  arb_gnt;
  logic          arb_found;
  logic          owner_req;

  assign next_owner = (32'(idx_q) == N - 1) ? '0 : idx_q + 1'b1;
  // On release the departing owner gets lowest priority by starting after it.
  assign arb_start  = (state_q == StGrant) ? next_owner : ptr_q;
  assign owner_req  = |(req & grant_q);

  always_comb begin
    int unsigned j;
    logic [N-1:0] sel;
    arb_gnt   = '0;
    arb_idx   = '0;
    arb_found = 1'b0;
    j         = 0;
    sel       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(arb_start) + k;
      if (j >= N) begin
        j = j - N;
      end
      sel = req >> j;
      if (!arb_found && sel[0]) begin
        arb_found = 1'b1;
        arb_gnt   = N'(1) << j;
        arb_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d = StGrant;
          grant_d = arb_gnt;
          idx_d   = arb_idx;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (owner_req && (hold_q < CW'(MAX_HOLD - 1))) begin
          hold_d = hold_q + 1'b1;
        end else begin
          ptr_d  = next_owner;
          hold_d = '0;
          if (arb_found) begin
            grant_d = arb_gnt;
            idx_d   = arb_idx;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < int'(N); i++) begin
      dout = dout | (din[i*K +: K] & {K{grant_q[i]}});
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = |grant_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl with N=4, K=8, MAX_HOLD=4.
module tb_rr_grant_ctrl;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        busy;
  logic [7:0]  dout;

  int n_pass;
  int n_checks;

  rr_grant_ctrl #(
    .N(4), .K(8), .MAX_HOLD(4), .IW(2), .CW(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .din(din),
    .grant(grant),
    .grant_idx(grant_idx),
    .busy(busy),
    .dout(dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    #12;
    if (grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", grant);
    else n_pass++;
    n_checks++;
    if (grant_idx !== 2'd0) $display("FAIL reset_idx got=%0d exp=0", grant_idx);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
    else n_pass++;
    n_checks++;
    if (dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", dout);
    else n_pass++;
    n_checks++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    if (grant !== 4'b0000) $display("FAIL idle_after_reset got=%b exp=0000", grant);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0101;
    step();
    if (grant !== 4'b0001) $display("FAIL b2b_first got=%b exp=0001", grant);
    else n_pass++;
    n_checks++;
    step();
    if (grant !== 4'b0001) $display("FAIL b2b_hold got=%b exp=0001", grant);
    else n_pass++;
    n_checks++;
    req = 4'b0100;
    step();
    if (grant !== 4'b0100) $display("FAIL b2b_handoff got=%b exp=0100", grant);
    else n_pass++;
    n_checks++;
    if (grant_idx !== 2'd2) $display("FAIL b2b_idx got=%0d exp=2", grant_idx);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", busy);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      step();
      exp_g = 4'b0001 << ((k / 4) % 4);
      if (grant !== exp_g) $display("FAIL fair_cycle%0d got=%b exp=%b", k, grant, exp_g);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL fair_busy%0d got=%b exp=1", k, busy);
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      step();
      if (grant !== 4'b0100 || grant_idx !== 2'd2)
        $display("FAIL single_cycle%0d got=%b/%0d exp=0100/2", k, grant, grant_idx);
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_routing();
    do_reset();
    req = 4'b0010;
    step();
    if (dout !== 8'h22) $display("FAIL route_owner1 got=%h exp=22", dout);
    else n_pass++;
    n_checks++;
    if (grant_idx !== 2'd1) $display("FAIL route_idx got=%0d exp=1", grant_idx);
    else n_pass++;
    n_checks++;
    req = 4'b0000;
    step();
    if (grant !== 4'b0000) $display("FAIL route_release got=%b exp=0000", grant);
    else n_pass++;
    n_checks++;
    if (dout !== 8'h00) $display("FAIL route_idle_dout got=%h exp=00", dout);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    step();
    step();
    if (dout !== 8'h33) $display("FAIL mid_owner2_dout got=%h exp=33", dout);
    else n_pass++;
    n_checks++;
    #3;
    reset_n = 1'b0;
    #1;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || busy !== 1'b0 || dout !== 8'h00)
      $display("FAIL mid_reset got=%b/%0d/%b/%h exp=0000/0/0/00", grant, grant_idx, busy, dout);
    else n_pass++;
    n_checks++;
    req = 4'b1000;
    #2;
    reset_n = 1'b1;
    step();
    if (grant !== 4'b1000) $display("FAIL mid_after got=%b exp=1000", grant);
    else n_pass++;
    n_checks++;
    if (dout !== 8'h44) $display("FAIL mid_after_dout got=%h exp=44", dout);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0101;
    step();
    if (grant !== 4'b0100) $display("FAIL sim_no_preempt got=%b exp=0100", grant);
    else n_pass++;
    n_checks++;
    req = 4'b1001;
    step();
    if (grant !== 4'b1000) $display("FAIL sim_rotate got=%b exp=1000", grant);
    else n_pass++;
    n_checks++;
    for (int k = 0; k < 3; k++) begin
      step();
      if (grant !== 4'b1000) $display("FAIL sim_hold%0d got=%b exp=1000", k, grant);
      else n_pass++;
      n_checks++;
    end
    step();
    if (grant !== 4'b0001) $display("FAIL sim_wrap got=%b exp=0001", grant);
    else n_pass++;
    n_checks++;
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    reset_n  = 1'b0;
    req      = 4'b0000;
    din      = {8'h44, 8'h33, 8'h22, 8'h11};
    test_reset();
    test_back_to_back();
    test_fairness();
    test_single();
    test_routing();
    test_reset_mid();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Round-robin arbiter/controller that shares one K-bit datapath (one-hot mux) among N requesters.
- Grants tenure to one requester at a time and holds it while the request stays asserted, up to MAX_HOLD cycles.
- Drives the one-hot select and routes the winner's data to the shared output.
- Sits in front of a shared resource, replacing fixed-priority arbitration that can starve high-index requesters.

Parameters:
- N, 4, number of requesters (N >= 2).
- K, 8, data width per requester.
- MAX_HOLD, 4, maximum consecutive grant cycles per tenure (>= 1).
- IW, 2, width of grant_idx; must satisfy 2^IW >= N.
- CW, 2, width of internal hold counter; must satisfy 2^CW >= MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  N  request per requester; level, held for the whole tenure.
- din  in  N*K  requester data, lane i = din[i*K+K-1 : i*K].
- grant  out  N  one-hot grant, registered; all-zero when idle.
- grant_idx  out  IW  binary index of the owner; 0 when idle.
- busy  out  1  equals |grant.
- dout  out  K  lane of din selected by grant; 0 when grant is 0; combinational from registered grant.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset, applied asynchronously at any time including mid-tenure:
  - grant=0, grant_idx=0, busy=0, dout=0.
  - Pointer ptr=0, hold_cnt=0, state IDLE.
  - Release of reset is taken synchronously; the first grant is possible at the first rising edge after reset_n goes high.
- State IDLE:
  - At an edge with req != 0, choose the winner by rotated priority: ptr highest, then ptr+1, ... wrapping mod N.
  - Load grant with that one-hot, set hold_cnt=0, go to GRANT. Latency from req sampled to grant visible: 1 cycle.
  - At an edge with req == 0, stay in IDLE.
- State GRANT (owner o):
  - Continue when req[o]=1 and hold_cnt < MAX_HOLD-1: hold_cnt+1, grant unchanged.
  - Release when req[o]=0, or when hold_cnt == MAX_HOLD-1 (timeout).
- On a release edge:
  - ptr <= (o+1) mod N.
  - Re-arbitrate in the same edge over the current req, rotating from (o+1) mod N. The owner therefore has lowest priority.
  - If any req is set, grant the new winner with hold_cnt=0 and no idle bubble. If only the timed-out owner still requests, it is re-granted immediately with hold_cnt=0.
  - If req == 0, grant=0 and go to IDLE.
- Tenure length: with req held, a tenure lasts exactly MAX_HOLD cycles. Grant stays asserted for the cycle in which the owner drops req and clears at the following edge.
- Requests that appear mid-tenure do not preempt the owner.
- grant is always one-hot or zero. grant_idx is always consistent with grant.
- ptr wraps from N-1 to 0. Non-power-of-two N: indices >= N are never granted.
- dout is the AND-OR mux of din lanes gated by grant bits; no latch, no X when idle.

Test Plan:
- Reset mid-tenure: N=4, MAX_HOLD=4, owner 2, assert reset_n=0 between edges -> grant=0000, grant_idx=0, busy=0, dout=0 immediately. After release, req=1000 -> grant=1000 one edge later (ptr was 0, so index 3 wins as the only requester).
- Back-to-back handoff: from idle, req=0101 -> grant=0001. Drop req[0] after 2 cycles -> at that edge grant=0100 with no zero cycle, grant_idx=2.
- Fairness under full load: req=1111 held -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 (wrap), busy never low.
- Single persistent requester: only req[2] held for 12 cycles -> grant=0100 continuous, with hold_cnt reset every 4 cycles and no gap.
- Data routing: din lanes = 8'h11, 8'h22, 8'h33, 8'h44 -> dout tracks owner (owner 1 gives 8'h22). With req=0000 after release -> dout=8'h00.
- Simultaneous events: owner 2 drops req on the same edge req[0] and req[3] rise -> grant=1000 (rotation from 3). On the next release, index 0 wins.
